// File: rtl/inv_cipher_core_if.sv
// Handshake and data bundle between an AES-128 decryption core and its host / key store.
interface inv_cipher_core_if;
  logic         start;
  logic [127:0] ciphertext;
  logic [127:0] round_key;
  logic [3:0]   key_idx;
  logic         busy;
  logic         done;
  logic [127:0] plaintext;

  modport master (
    output start, ciphertext, round_key,
    input  key_idx, busy, done, plaintext
  );

  modport slave (
    input  start, ciphertext, round_key,
    output key_idx, busy, done, plaintext
  );
endinterface

// File: rtl/inv_cipher_core.sv
// Iterative AES-128 decryption: one full inverse round per clock, ten clocks per block,
// round keys fetched from an external store addressed by key_idx.
module inv_sub_bytes (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  for (genvar i = 0; i < 16; i++) begin : g_lane
    assign dout[127-8*i -: 8] = INV_SBOX[din[127-8*i -: 8]];
  end
endmodule

module inv_cipher_core (
  input  logic             clk,
  input  logic             rst,
  inv_cipher_core_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state, state_nx;
  logic [3:0]   rnd;
  logic [127:0] s_p0;
  logic [127:0] pt_p0;
  logic         done_p0;
  logic [127:0] sr, sb, t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k of the block is row k%4 of column k/4; row r shifts right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+4-row)%4)+row) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

  // Single-cycle inverse round datapath
  assign sr = inv_shift_rows(s_p0);

  inv_sub_bytes u_inv_sub_bytes (
    .din  (sr),
    .dout (sb)
  );

  assign t = sb ^ bus.round_key;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (rnd == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = 1'b0;
    bus.key_idx = 4'd10;
    if (state == RUN) begin
      bus.busy    = 1'b1;
      bus.key_idx = rnd;
    end
  end

  // State register, round counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd     <= 4'd0;
      s_p0    <= '0;
      pt_p0   <= '0;
      done_p0 <= 1'b0;
    end else begin
      done_p0 <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          s_p0 <= bus.ciphertext ^ bus.round_key;
          rnd  <= 4'd9;
        end
      end else if (rnd != 4'd0) begin
        s_p0 <= inv_mix_columns(t);
        rnd  <= rnd - 4'd1;
      end else begin
        pt_p0   <= t;
        done_p0 <= 1'b1;
      end
    end
  end

  assign bus.plaintext = pt_p0;
  assign bus.done      = done_p0;
endmodule

// File: tb/tb_inv_cipher_core.sv
// Randomized and known-answer bench for inv_cipher_core against a byte-level AES-128 model.
module tb_inv_cipher_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_cipher_core_if bus ();

  inv_cipher_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] A1_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic [7:0]   sbox_tab  [256];
  logic [7:0]   isbox_tab [256];
  logic [127:0] rk_tab    [16];
  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  assign bus.round_key = rk_tab[bus.key_idx];

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tab[x] = b;
      isbox_tab[b] = 8'(x);
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tw;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sbox_tab[tw[23:16]], sbox_tab[tw[15:8]], sbox_tab[tw[7:0]], sbox_tab[tw[31:24]]}
             ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [7:0] st [16], tmp [16];
    logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] res;
    for (int i = 0; i < 16; i++) st[i] = ct[127-8*i -: 8] ^ rk_tab[10][127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          tmp[4*c+row] = isbox_tab[st[4*((c+4-row)%4)+row]] ^ rk_tab[r][127-8*(4*c+row) -: 8];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) begin
          if (r == 0) st[4*c+row] = tmp[4*c+row];
          else begin
            st[4*c+row] = 8'h00;
            for (int k = 0; k < 4; k++)
              st[4*c+row] ^= gmul(coef[(k+4-row)%4], tmp[4*c+k]);
          end
        end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  task automatic launch(input logic [127:0] ct);
    bus.ciphertext = ct;
    bus.start = 1'b1;
    chk("key_idx_start", 128'(bus.key_idx), 128'd10);
    tick();
    bus.start = 1'b0;
    bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Follows the ten rounds after the accepting edge and stops in the done cycle.
  task automatic rounds(input logic [127:0] exp, input string tag);
    for (int i = 9; i >= 0; i--) begin
      chk({tag, "_key_idx"}, 128'(bus.key_idx), 128'(i));
      chk({tag, "_busy"}, 128'(bus.busy), 128'd1);
      chk({tag, "_done_early"}, 128'(bus.done), 128'd0);
      tick();
    end
    chk({tag, "_done"}, 128'(bus.done), 128'd1);
    chk({tag, "_busy_low"}, 128'(bus.busy), 128'd0);
    chk({tag, "_plaintext"}, bus.plaintext, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    build_sbox();
    load_key(C1_KEY);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.ciphertext = C1_CT;

    // reset values, with start held during reset
    tick();
    chk("rst_done", 128'(bus.done), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_plaintext", bus.plaintext, 128'd0);
    chk("rst_key_idx", 128'(bus.key_idx), 128'd10);
    tick();
    chk("rst_busy2", 128'(bus.busy), 128'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("rst_start_dropped", 128'(bus.busy), 128'd0);
    chk("rst_no_done", 128'(done_cnt), 128'd0);

    // known-answer vectors
    launch(C1_CT);
    rounds(C1_PT, "c1");
    tick();
    chk("c1_done_pulse", 128'(bus.done), 128'd0);
    chk("c1_pt_hold", bus.plaintext, C1_PT);
    load_key(A1_KEY);
    launch(A1_CT);
    rounds(A1_PT, "a1");
    tick();

    // back-to-back: next start accepted in the done cycle
    load_key(C1_KEY);
    done_cnt = 0;
    launch(C1_CT);
    rounds(C1_PT, "b2b_c1");
    load_key(A1_KEY);
    launch(A1_CT);
    rounds(A1_PT, "b2b_a1");
    tick();
    chk("b2b_done_cnt", 128'(done_cnt), 128'd2);

    // start while busy is ignored
    load_key(C1_KEY);
    done_cnt = 0;
    launch(C1_CT);
    repeat (4) tick();
    chk("busy_start_round", 128'(bus.key_idx), 128'd5);
    bus.start = 1'b1;
    bus.ciphertext = A1_CT;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 20 && bus.done !== 1'b1; k++) tick();
    chk("busy_start_done", 128'(bus.done), 128'd1);
    chk("busy_start_pt", bus.plaintext, C1_PT);
    repeat (12) tick();
    chk("busy_start_done_cnt", 128'(done_cnt), 128'd1);
    chk("busy_start_idle", 128'(bus.busy), 128'd0);

    // reset mid-operation
    launch(C1_CT);
    repeat (5) tick();
    chk("mid_rst_round", 128'(bus.key_idx), 128'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 128'(bus.busy), 128'd0);
    chk("mid_rst_pt", bus.plaintext, 128'd0);
    chk("mid_rst_key_idx", 128'(bus.key_idx), 128'd10);
    done_cnt = 0;
    repeat (12) tick();
    chk("mid_rst_no_done", 128'(done_cnt), 128'd0);
    launch(C1_CT);
    rounds(C1_PT, "after_rst");
    tick();

    // randomized keys and blocks against the model
    for (int n = 0; n < 16; n++) begin
      logic [127:0] key, ct, exp;
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      exp = ref_dec(ct);
      launch(ct);
      rounds(exp, "rand");
      if (n % 2 == 0) tick();
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
